gate_response_checker: RTL
==========================

Name: gate_response_checker

Overview:
Self-checking response monitor for the 3-input AND/OR gate block. It sits beside the stimulus counter in the bench and samples each applied input vector together with the gate's two outputs. It checks each sample against a golden AND/OR model, counts mismatches, records the first failing vector, and tracks coverage of all 2^N_IN input vectors. It reports pass/fail when the run finishes, either because every vector has been covered or because the run timed out.

Parameters:
N_IN, 3, number of gate inputs; coverage space is 2^N_IN vectors
ERR_W, 8, width of the mismatch counter (saturating)
TIMEOUT, 64, maximum RUN cycles before a forced finish; must be >= 1

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle pulse; clears all results and begins a run
vec_valid  input  1  vec_in/dut_and/dut_or hold a sample this cycle
vec_in  input  N_IN  input vector applied to the gate
dut_and  input  1  gate AND output for vec_in (same cycle)
dut_or  input  1  gate OR output for vec_in (same cycle)
busy  output  1  high while in RUN
done  output  1  high while in DONE
pass  output  1  valid while done: no mismatches and full coverage
err_count  output  ERR_W  mismatch count, saturates at all-ones
cov_map  output  2^N_IN  bit i set once vector i has been sampled in this run
first_fail_valid  output  1  a mismatch has been captured this run
first_fail_vec  output  N_IN  vec_in of the first mismatching sample

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. busy, done, pass, err_count, cov_map, first_fail_valid, first_fail_vec and the timeout counter all go to 0. Reset overrides every other input, including in the middle of a run.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - Samples are ignored.
  - start=1 -> RUN next cycle, with all results cleared.
  - A sample presented in the same cycle as start is not checked.
- RUN, on each cycle with vec_valid=1:
  - exp_and = AND-reduce(vec_in); exp_or = OR-reduce(vec_in).
  - Mismatch when dut_and != exp_and or dut_or != exp_or.
  - On mismatch: err_count += 1, unless it is already all-ones (stays there).
  - If first_fail_valid=0: capture first_fail_vec = vec_in and set first_fail_valid=1. Later mismatches do not overwrite the capture.
  - cov_map[vec_in] <= 1; repeated vectors are allowed and harmless.
- Timeout counter:
  - Counts every RUN cycle, whether or not vec_valid is high.
  - Timeout fires on the RUN cycle where the counter reaches TIMEOUT-1.
- RUN -> DONE, taken on the posedge that processes one of these events:
  - the sample that completes cov_map (all ones), or
  - the timeout cycle.
  - The completing sample's check is included in the results.
  - If coverage completes and the timeout fires in the same cycle, DONE is entered once, with full coverage.
- In DONE:
  - done=1; pass = (err_count==0) && (cov_map all ones).
  - All results hold and samples are ignored.
- start in RUN or DONE: restart immediately.
  - Results are cleared and the timeout counter resets; state becomes (or stays) RUN.
  - A sample in the same cycle as start is discarded (clear wins).
- busy and done are never high together; both are low in IDLE.
- pass is 0 whenever done=0.

Test Plan:
1. Reset, pulse start, drive vectors 0..7 in order with correct outputs, one per cycle -> done=1 on the cycle after vector 7 is sampled, pass=1, err_count=0, cov_map=8'hFF, first_fail_valid=0.
2. Same as 1, but drive dut_and=1 at vec_in=3'b101 -> err_count=1, first_fail_valid=1, first_fail_vec=3'd5, cov_map=8'hFF, pass=0.
3. With TIMEOUT=64, repeatedly drive only vectors 0..3 with correct outputs -> done after exactly 64 RUN cycles, cov_map=8'h0F, err_count=0, pass=0.
4. With TIMEOUT=400, drive vec_in=0 with dut_or=1 on every cycle -> err_count saturates at 8'hFF and stays there, first_fail_vec=0, pass=0 at done.
5. Start a run, sample 4 vectors, then assert rst -> next cycle every output is 0 and state is IDLE; further valid samples leave err_count and cov_map at 0.
6. In DONE after scenario 2, assert start together with a mismatching sample -> next cycle busy=1, done=0, err_count=0, cov_map=0, first_fail_valid=0 (sample discarded).

Source files
------------

// File: rtl/gate_response_checker.sv
// Response checker for the 3-input AND/OR gate block.
// Compares each sampled vector against a golden AND/OR model, counts mismatches
// (saturating), latches the first failing vector and tracks input-space coverage.
// A run ends on full coverage or after TIMEOUT RUN cycles.
module gate_response_checker #(
  parameter int unsigned N_IN    = 3,
  parameter int unsigned ERR_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 vec_valid_i,
  input  logic [N_IN-1:0]      vec_in_i,
  input  logic                 dut_and_i,
  input  logic                 dut_or_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_W-1:0]     err_count_o,
  output logic [2**N_IN-1:0]   cov_map_o,
  output logic                 first_fail_valid_o,
  output logic [N_IN-1:0]      first_fail_vec_o
);

  localparam int unsigned NumVec = 2 ** N_IN;
  localparam int unsigned CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   tmo_q, tmo_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [NumVec-1:0] cov_q, cov_d;
  logic              ffv_q, ffv_d;
  logic [N_IN-1:0]   ffvec_q, ffvec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic exp_and, exp_or, mismatch;

  // Golden model of the gate under test.
  always_comb begin
    exp_and  = &vec_in_i;
    exp_or   = |vec_in_i;
    mismatch = (dut_and_i != exp_and) || (dut_or_i != exp_or);
  end

  // Next-state: start always restarts (discarding any same-cycle sample),
  // otherwise RUN checks samples and decides when the run is over.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    cov_d   = cov_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    if (start_i) begin
      state_d = StRun;
      tmo_d   = '0;
      err_d   = '0;
      cov_d   = '0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
    end else begin
      case (state_q)
        StRun: begin
          tmo_d = tmo_q + 1'b1;
          if (vec_valid_i) begin
            if (mismatch) begin
              if (err_q != '1) begin
                err_d = err_q + 1'b1;
              end
              if (!ffv_q) begin
                ffv_d   = 1'b1;
                ffvec_d = vec_in_i;
              end
            end
            cov_d[vec_in_i] = 1'b1;
          end
          // Coverage and timeout on the same cycle collapse into one exit.
          if ((&cov_d) || (tmo_q == TmoLast)) begin
            state_d = StDone;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
    pass_d = (state_d == StDone) && (err_d == '0) && (&cov_d);
  end

  // State and result registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign err_count_o        = err_q;
  assign cov_map_o          = cov_q;
  assign first_fail_valid_o = ffv_q;
  assign first_fail_vec_o   = ffvec_q;

endmodule
